// File: rtl/mac_pkg.sv
// Shared types, default widths and saturating-add helper for mac_accum.
// Saturation is enabled by defining MAC_ACCUM_SAT_EN.
package mac_pkg;

    localparam int P_W   = 43;
    localparam int ACC_W = 48;
    localparam int CNT_W = 8;

    typedef enum logic {
        IDLE,
        ACCUM
    } mac_state_e;

    // Clamping signed add at ACC_W; returns {ovf, sum}.
    function automatic logic [ACC_W:0] sat_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
        logic signed [ACC_W:0] w_full;
        logic                  w_ovf;
        logic [ACC_W-1:0]      w_sum;
        w_full = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        w_ovf  = w_full[ACC_W] ^ w_full[ACC_W-1];
        w_sum  = w_full[ACC_W-1:0];
        if (w_ovf) begin
            w_sum = w_full[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
        end
        return {w_ovf, w_sum};
    endfunction

endpackage

// File: rtl/mac_accum_if.sv
// Product-stream input and frame-result output bundle of mac_accum.
// slave is the accumulator's view, master the producer/consumer view.
interface mac_accum_if
    import mac_pkg::*;
#(
    parameter int P_WIDTH   = P_W,
    parameter int ACC_WIDTH = ACC_W,
    parameter int CNT_WIDTH = CNT_W
) ();

    logic [P_WIDTH-1:0]   prod_i;
    logic                 in_valid_i;
    logic                 in_last_i;
    logic                 in_ready_o;
    logic [ACC_WIDTH-1:0] out_sum_o;
    logic [CNT_WIDTH-1:0] out_cnt_o;
    logic                 out_ovf_o;
    logic                 out_valid_o;
    logic                 out_ready_i;

    modport slave (
        input  prod_i,
        input  in_valid_i,
        input  in_last_i,
        output in_ready_o,
        output out_sum_o,
        output out_cnt_o,
        output out_ovf_o,
        output out_valid_o,
        input  out_ready_i
    );

    modport master (
        output prod_i,
        output in_valid_i,
        output in_last_i,
        input  in_ready_o,
        input  out_sum_o,
        input  out_cnt_o,
        input  out_ovf_o,
        input  out_valid_o,
        output out_ready_i
    );

endinterface

// File: rtl/mac_sat_add.sv
// Signed accumulator adder; wraps by default, clamps with overflow
// flag when MAC_ACCUM_SAT_EN is defined.
module mac_sat_add #(
    parameter int ACC_WIDTH = 48
) (
    input  logic signed [ACC_WIDTH-1:0] i_a,
    input  logic signed [ACC_WIDTH-1:0] i_b,
    output logic signed [ACC_WIDTH-1:0] o_sum,
    output logic                        o_ovf
);

`ifdef MAC_ACCUM_SAT_EN
    logic signed [ACC_WIDTH:0] w_full;
    logic                      w_ovf;

    assign w_full = {i_a[ACC_WIDTH-1], i_a} + {i_b[ACC_WIDTH-1], i_b};
    assign w_ovf  = w_full[ACC_WIDTH] ^ w_full[ACC_WIDTH-1];

    // Clamp toward the sign of the true (wide) result on overflow.
    always_comb begin
        o_sum = w_full[ACC_WIDTH-1:0];
        if (w_ovf) begin
            o_sum = w_full[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                      : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end

    assign o_ovf = w_ovf;
`else
    assign o_sum = i_a + i_b;
    assign o_ovf = 1'b0;
`endif

endmodule

// File: rtl/mac_accum.sv
// Frame accumulator behind the DSP multiplier: sums product beats into
// one result per frame. Saturation enabled by MAC_ACCUM_SAT_EN.
module mac_accum
    import mac_pkg::*;
#(
    parameter int P_WIDTH   = P_W,
    parameter int ACC_WIDTH = ACC_W,
    parameter int CNT_WIDTH = CNT_W
) (
    input  logic        clk_i,
    input  logic        rst_i,
    mac_accum_if.slave  bus
);

    localparam logic [CNT_WIDTH-1:0] MAX_LEN = '1;

    mac_state_e                  r_state;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic [CNT_WIDTH-1:0]        r_cnt;
    logic                        r_ovf;
    logic signed [ACC_WIDTH-1:0] r_out_sum;
    logic [CNT_WIDTH-1:0]        r_out_cnt;
    logic                        r_out_ovf;
    logic                        r_out_valid;

    logic signed [P_WIDTH-1:0]   w_prod;
    logic signed [ACC_WIDTH-1:0] w_prod_ext;
    logic signed [ACC_WIDTH-1:0] w_add_a;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic                        w_add_ovf;
    logic                        w_ovf_nxt;
    logic [CNT_WIDTH-1:0]        w_cnt_nxt;
    logic                        w_in_ready;
    logic                        w_beat;
    logic                        w_close;

    assign w_prod     = bus.prod_i;
    assign w_prod_ext = ACC_WIDTH'(w_prod);

    // A new frame starts from zero even if acc was left non-zero.
    assign w_add_a   = (r_state == IDLE) ? '0 : r_acc;
    assign w_cnt_nxt = (r_state == IDLE) ? CNT_WIDTH'(1) : r_cnt + 1'b1;
    assign w_ovf_nxt = ((r_state == ACCUM) && r_ovf) || w_add_ovf;

    assign w_in_ready = !rst_i && (!r_out_valid || bus.out_ready_i);
    assign w_beat     = bus.in_valid_i && w_in_ready;
    assign w_close    = w_beat && (bus.in_last_i || (w_cnt_nxt == MAX_LEN));

    mac_sat_add #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_add (
        .i_a   (w_add_a),
        .i_b   (w_prod_ext),
        .o_sum (w_sum),
        .o_ovf (w_add_ovf)
    );

    // Frame FSM, accumulator, beat counter and single-entry result buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_sum   <= '0;
            r_out_cnt   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (r_out_valid && bus.out_ready_i) begin
                r_out_valid <= 1'b0;
            end
            if (w_beat) begin
                if (w_close) begin
                    r_out_sum   <= w_sum;
                    r_out_cnt   <= w_cnt_nxt;
                    r_out_ovf   <= w_ovf_nxt;
                    r_out_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                    r_ovf       <= 1'b0;
                    r_state     <= IDLE;
                end else begin
                    r_acc   <= w_sum;
                    r_cnt   <= w_cnt_nxt;
                    r_ovf   <= w_ovf_nxt;
                    r_state <= ACCUM;
                end
            end
        end
    end

    assign bus.in_ready_o  = w_in_ready;
    assign bus.out_sum_o   = r_out_sum;
    assign bus.out_cnt_o   = r_out_cnt;
    assign bus.out_ovf_o   = r_out_ovf;
    assign bus.out_valid_o = r_out_valid;

endmodule

// File: tb/tb_mac_accum.sv
// Directed self-checking bench for mac_accum (default widths).
// Build with MAC_ACCUM_SAT_EN defined to exercise saturation.
module tb_mac_accum;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_vld;
    logic [47:0] e;
    longint x;

    mac_accum_if bus ();

    mac_accum dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input longint p, input logic l);
        bus.prod_i     = p[42:0];
        bus.in_valid_i = 1'b1;
        bus.in_last_i  = l;
    endtask

    task automatic idle();
        bus.in_valid_i = 1'b0;
        bus.in_last_i  = 1'b0;
        bus.prod_i     = '0;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic chks(input string tag, input logic [47:0] obs,
                        input logic [47:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_rdy"}, int'(bus.in_ready_o), 0);
        chk({tag, "_vld"}, int'(bus.out_valid_o), 0);
        chks({tag, "_sum"}, bus.out_sum_o, 48'h0);
        chk({tag, "_cnt"}, int'(bus.out_cnt_o), 0);
        chk({tag, "_ovf"}, int'(bus.out_ovf_o), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        bus.out_ready_i = 1'b1;
        rst = 1'b1;
        step();
        chk_reset("rst");
        rst = 1'b0;
        step();

        // basic frame 5, -3, 10
        drive(5, 1'b0);
        step();
        drive(-3, 1'b0);
        step();
        chk("t1_vld_early", int'(bus.out_valid_o), 0);
        drive(10, 1'b1);
        step();
        idle();
        chk("t1_vld", int'(bus.out_valid_o), 1);
        chks("t1_sum", bus.out_sum_o, 48'd12);
        chk("t1_cnt", int'(bus.out_cnt_o), 3);
        chk("t1_ovf", int'(bus.out_ovf_o), 0);
        step();
        chk("t1_vld_clr", int'(bus.out_valid_o), 0);

        // backpressure
        bus.out_ready_i = 1'b0;
        drive(1, 1'b0);
        step();
        drive(2, 1'b1);
        step();
        chk("t2_vld", int'(bus.out_valid_o), 1);
        chks("t2_sum", bus.out_sum_o, 48'd3);
        chk("t2_cnt", int'(bus.out_cnt_o), 2);
        chk("t2_rdy_lo", int'(bus.in_ready_o), 0);
        drive(4, 1'b1);
        step();
        step();
        chk("t2_vld_hold", int'(bus.out_valid_o), 1);
        chks("t2_sum_hold", bus.out_sum_o, 48'd3);
        chk("t2_rdy_hold", int'(bus.in_ready_o), 0);
        bus.out_ready_i = 1'b1;
        #1;
        chk("t2_rdy_hi", int'(bus.in_ready_o), 1);
        step();
        idle();
        chk("t2_vld2", int'(bus.out_valid_o), 1);
        chks("t2_sum2", bus.out_sum_o, 48'd4);
        chk("t2_cnt2", int'(bus.out_cnt_o), 1);
        step();
        chk("t2_vld_clr", int'(bus.out_valid_o), 0);

        // back-to-back single-beat frames
        drive(-7, 1'b1);
        chk("t3_rdy0", int'(bus.in_ready_o), 1);
        step();
        e = -48'sd7;
        chk("t3_vld_a", int'(bus.out_valid_o), 1);
        chks("t3_sum_a", bus.out_sum_o, e);
        chk("t3_cnt_a", int'(bus.out_cnt_o), 1);
        chk("t3_rdy_a", int'(bus.in_ready_o), 1);
        drive(9, 1'b1);
        step();
        idle();
        chk("t3_vld_b", int'(bus.out_valid_o), 1);
        chks("t3_sum_b", bus.out_sum_o, 48'd9);
        chk("t3_cnt_b", int'(bus.out_cnt_o), 1);
        chk("t3_rdy_b", int'(bus.in_ready_o), 1);
        step();
        chk("t3_vld_clr", int'(bus.out_valid_o), 0);

        // forced close at 255 beats
        n_vld = 0;
        for (int i = 0; i < 255; i++) begin
            drive(1, 1'b0);
            step();
            if (i < 254 && bus.out_valid_o) n_vld++;
        end
        idle();
        chk("t4_no_early", n_vld, 0);
        chk("t4_vld", int'(bus.out_valid_o), 1);
        chks("t4_sum", bus.out_sum_o, 48'd255);
        chk("t4_cnt", int'(bus.out_cnt_o), 255);
        drive(2, 1'b1);
        step();
        idle();
        chk("t4_vld2", int'(bus.out_valid_o), 1);
        chks("t4_sum2", bus.out_sum_o, 48'd2);
        chk("t4_cnt2", int'(bus.out_cnt_o), 1);
        step();

        // reset mid-frame
        drive(100, 1'b0);
        step();
        drive(100, 1'b0);
        step();
        idle();
        rst = 1'b1;
        step();
        chk_reset("t5_r1");
        step();
        chk_reset("t5_r2");
        rst = 1'b0;
        drive(6, 1'b1);
        step();
        idle();
        chk("t5_vld", int'(bus.out_valid_o), 1);
        chks("t5_sum", bus.out_sum_o, 48'd6);
        chk("t5_cnt", int'(bus.out_cnt_o), 1);
        step();

        // overflow: 40 beats of 2^42-1
        for (int i = 0; i < 40; i++) begin
            drive((64'sd1 <<< 42) - 1, i == 39);
            step();
        end
        idle();
`ifdef MAC_ACCUM_SAT_EN
        e = 48'h7FFF_FFFF_FFFF;
        chk("t6_ovf", int'(bus.out_ovf_o), 1);
`else
        x = -(64'sd3 <<< 45) - 40;
        e = x[47:0];
        chk("t6_ovf", int'(bus.out_ovf_o), 0);
`endif
        chk("t6_vld", int'(bus.out_valid_o), 1);
        chks("t6_sum", bus.out_sum_o, e);
        chk("t6_cnt", int'(bus.out_cnt_o), 40);
        step();

        // flag must not leak into the next frame
        drive(1, 1'b1);
        step();
        idle();
        chk("t6_ovf_clr", int'(bus.out_ovf_o), 0);
        chks("t6_sum_nxt", bus.out_sum_o, 48'd1);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
